// File: rtl/ann_window_scheduler.sv
// Window scheduler for the cascaded ANN classifier. It accepts one window, loads its
// features, steps the ANN stages under a watchdog, reports the result, then clears the ANN.
module ann_window_scheduler #(
    parameter int COORD_W    = 10,
    parameter int NUM_STAGES = 12,
    parameter int TIMEOUT    = 4095
) (
    input  logic               iClk,
    input  logic               iReset_n,
    input  logic               iWin_valid,
    input  logic [COORD_W-1:0] iWin_x,
    input  logic [COORD_W-1:0] iWin_y,
    output logic               oWin_ready,
    output logic               oLoad_start,
    output logic [COORD_W-1:0] oLoad_x,
    output logic [COORD_W-1:0] oLoad_y,
    input  logic               iLoad_done,
    output logic               oRun_ANN,
    input  logic               iFinish_Stage,
    input  logic               iStage_pass,
    output logic               oANN_clear,
    output logic               oResult_valid,
    output logic               oResult_face,
    output logic [3:0]         oResult_stage,
    input  logic               iResult_ready,
    output logic               oBusy,
    output logic               oTimeout_err,
    output logic [15:0]        oWin_count,
    output logic [15:0]        oFace_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD, WAIT_LOAD, RUN, REPORT, CLEAR
    } state_t;

    state_t             state_reg;
    logic [3:0]         stage_cnt_reg;
    logic [WD_W-1:0]    watchdog_reg;
    logic               win_ready_reg;
    logic               load_start_reg;
    logic [COORD_W-1:0] load_x_reg;
    logic [COORD_W-1:0] load_y_reg;
    logic               run_reg;
    logic               ann_clear_reg;
    logic               result_valid_reg;
    logic               result_face_reg;
    logic               busy_reg;
    logic               timeout_err_reg;
    logic [15:0]        win_count_reg;
    logic [15:0]        face_count_reg;

    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_reg        <= IDLE;
            stage_cnt_reg    <= '0;
            watchdog_reg     <= '0;
            win_ready_reg    <= 1'b0;
            load_start_reg   <= 1'b0;
            load_x_reg       <= '0;
            load_y_reg       <= '0;
            run_reg          <= 1'b0;
            ann_clear_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            result_face_reg  <= 1'b0;
            busy_reg         <= 1'b0;
            timeout_err_reg  <= 1'b0;
            win_count_reg    <= '0;
            face_count_reg   <= '0;
        end else begin
            load_start_reg <= 1'b0;
            ann_clear_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    win_ready_reg <= 1'b1;
                    if (iWin_valid && win_ready_reg) begin
                        load_x_reg     <= iWin_x;
                        load_y_reg     <= iWin_y;
                        stage_cnt_reg  <= '0;
                        watchdog_reg   <= '0;
                        win_ready_reg  <= 1'b0;
                        load_start_reg <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= LOAD;
                    end
                end
                LOAD: state_reg <= WAIT_LOAD;
                WAIT_LOAD: begin
                    if (iLoad_done) begin
                        run_reg   <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A stage completion always takes priority over the watchdog expiring.
                    if (iFinish_Stage) begin
                        if (iStage_pass && stage_cnt_reg != LAST_STAGE) begin
                            stage_cnt_reg <= stage_cnt_reg + 4'd1;
                            watchdog_reg  <= '0;
                        end else begin
                            result_face_reg  <= iStage_pass;
                            result_valid_reg <= 1'b1;
                            run_reg          <= 1'b0;
                            state_reg        <= REPORT;
                        end
                    end else if (watchdog_reg == WD_LAST) begin
                        timeout_err_reg  <= 1'b1;
                        result_face_reg  <= 1'b0;
                        result_valid_reg <= 1'b1;
                        run_reg          <= 1'b0;
                        state_reg        <= REPORT;
                    end else begin
                        watchdog_reg <= watchdog_reg + 1'b1;
                    end
                end
                REPORT: begin
                    if (iResult_ready) begin
                        result_valid_reg <= 1'b0;
                        if (win_count_reg != 16'hFFFF)
                            win_count_reg <= win_count_reg + 16'd1;
                        if (result_face_reg && face_count_reg != 16'hFFFF)
                            face_count_reg <= face_count_reg + 16'd1;
                        ann_clear_reg <= 1'b1;
                        state_reg     <= CLEAR;
                    end
                end
                CLEAR: begin
                    win_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign oWin_ready    = win_ready_reg;
    assign oLoad_start   = load_start_reg;
    assign oLoad_x       = load_x_reg;
    assign oLoad_y       = load_y_reg;
    assign oRun_ANN      = run_reg;
    assign oANN_clear    = ann_clear_reg;
    assign oResult_valid = result_valid_reg;
    assign oResult_face  = result_face_reg;
    assign oResult_stage = stage_cnt_reg;
    assign oBusy         = busy_reg;
    assign oTimeout_err  = timeout_err_reg;
    assign oWin_count    = win_count_reg;
    assign oFace_count   = face_count_reg;

endmodule

// File: tb/tb_ann_window_scheduler.sv
// Directed bench for ann_window_scheduler: face, reject, backpressure, watchdog,
// saturation and mid-run reset, with hand-computed expectations.
module tb_ann_window_scheduler;
    localparam int TIMEOUT = 4095;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        win_valid;
    logic [9:0]  win_x, win_y;
    logic        win_ready;
    logic        load_start;
    logic [9:0]  load_x, load_y;
    logic        load_done;
    logic        run_ann;
    logic        finish_stage;
    logic        stage_pass;
    logic        ann_clear;
    logic        result_valid;
    logic        result_face;
    logic [3:0]  result_stage;
    logic        result_ready;
    logic        busy;
    logic        timeout_err;
    logic [15:0] win_count, face_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ann_window_scheduler #(.COORD_W(10), .NUM_STAGES(12), .TIMEOUT(TIMEOUT)) dut (
        .iClk(clk), .iReset_n(rst_n),
        .iWin_valid(win_valid), .iWin_x(win_x), .iWin_y(win_y), .oWin_ready(win_ready),
        .oLoad_start(load_start), .oLoad_x(load_x), .oLoad_y(load_y), .iLoad_done(load_done),
        .oRun_ANN(run_ann), .iFinish_Stage(finish_stage), .iStage_pass(stage_pass),
        .oANN_clear(ann_clear), .oResult_valid(result_valid), .oResult_face(result_face),
        .oResult_stage(result_stage), .iResult_ready(result_ready), .oBusy(busy),
        .oTimeout_err(timeout_err), .oWin_count(win_count), .oFace_count(face_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic accept_window(input logic [9:0] x, input logic [9:0] y);
        win_valid = 1'b1; win_x = x; win_y = y;
        step();
        win_valid = 1'b0;
    endtask

    task automatic load_to_run();
        step();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic stage(input logic pass);
        finish_stage = 1'b1; stage_pass = pass;
        step();
        finish_stage = 1'b0; stage_pass = 1'b0;
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst_n = 1'b0; win_valid = 1'b0; win_x = '0; win_y = '0; load_done = 1'b0;
        finish_stage = 1'b0; stage_pass = 1'b0; result_ready = 1'b0;
        step(); step();
        chk("rst_win_ready", 32'(win_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_counts", {win_count, face_count}, 0);
        chk("rst_pulses", {29'd0, load_start, ann_clear, result_valid}, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(win_ready), 1);

        // Face window: all 12 stages pass.
        accept_window(10'd37, 10'd120);
        chk("face_load_start", 32'(load_start), 1);
        chk("face_load_xy", {load_x, load_y}, {10'd37, 10'd120});
        chk("face_busy_not_ready", {busy, win_ready}, 2'b10);
        step();
        chk("face_load_start_1cyc", 32'(load_start), 0);
        repeat (3) step();
        chk("face_wait_no_run", 32'(run_ann), 0);
        load_done = 1'b1; step(); load_done = 1'b0;
        chk("face_run", 32'(run_ann), 1);
        for (int i = 0; i < 11; i++) begin
            stage(1'b1);
            step();
        end
        chk("face_still_run", {run_ann, result_valid}, 2'b10);
        stage(1'b1);
        chk("face_result", {run_ann, result_valid, result_face, result_stage}, {3'b011, 4'd11});
        handshake();
        chk("face_clear", {ann_clear, result_valid}, 2'b10);
        chk("face_counts", {win_count, face_count}, {16'd1, 16'd1});
        step();
        chk("face_idle", {ann_clear, win_ready, busy}, 3'b010);

        // Load done and finish pulses outside their states are ignored.
        load_done = 1'b1; finish_stage = 1'b1; stage_pass = 1'b1;
        step();
        load_done = 1'b0; finish_stage = 1'b0; stage_pass = 1'b0;
        chk("idle_ignore", {busy, run_ann, result_valid}, 0);

        // Early reject on stage 2, then backpressure with a new window pending.
        accept_window(10'd5, 10'd6);
        load_to_run();
        stage(1'b1); stage(1'b1); stage(1'b0);
        chk("rej_result", {result_valid, result_face, result_stage}, {2'b10, 4'd2});
        win_valid = 1'b1; win_x = 10'd99; win_y = 10'd98;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold", {result_valid, result_face, result_stage, win_ready, load_start},
                {2'b10, 4'd2, 2'b00});
        end
        chk("bp_xy_kept", {load_x, load_y}, {10'd5, 10'd6});
        win_valid = 1'b0;
        handshake();
        chk("rej_clear", 32'(ann_clear), 1);
        chk("rej_counts", {win_count, face_count}, {16'd2, 16'd1});
        step();
        chk("rej_clear_once", {ann_clear, win_ready}, 2'b01);

        // Finish on the cycle the watchdog would expire: the stage wins.
        accept_window(10'd1, 10'd2);
        load_to_run();
        repeat (TIMEOUT - 1) step();
        chk("wd_edge_pre", {run_ann, result_valid, timeout_err}, 3'b100);
        stage(1'b1);
        chk("wd_edge_no_err", {run_ann, result_valid, timeout_err}, 3'b100);
        stage(1'b0);
        chk("wd_edge_result", {result_valid, result_face, result_stage, timeout_err},
            {2'b10, 4'd1, 1'b0});
        handshake();
        step();

        // Watchdog expiry with ready held high ahead of REPORT.
        accept_window(10'd3, 10'd4);
        load_to_run();
        result_ready = 1'b1;
        repeat (TIMEOUT - 1) step();
        chk("wd_pre_expiry", {run_ann, result_valid, timeout_err}, 3'b100);
        step();
        chk("wd_report", {run_ann, result_valid, result_face, timeout_err, result_stage},
            {4'b0101, 4'd0});
        step();
        chk("wd_valid_1cyc", {result_valid, ann_clear}, 2'b01);
        result_ready = 1'b0;
        chk("wd_counts", {win_count, face_count}, {16'd4, 16'd1});
        step();
        chk("wd_sticky", {timeout_err, win_ready}, 2'b11);

        // Saturation: counters set just below the limit, then two more faces.
        force dut.win_count_reg = 16'hFFFE;
        force dut.face_count_reg = 16'hFFFE;
        step();
        release dut.win_count_reg;
        release dut.face_count_reg;
        for (int w = 0; w < 2; w++) begin
            accept_window(10'd7, 10'd8);
            load_to_run();
            for (int i = 0; i < 12; i++) stage(1'b1);
            chk("sat_face", {result_valid, result_face}, 2'b11);
            handshake();
            step();
            chk("sat_counts", {win_count, face_count}, {16'hFFFF, 16'hFFFF});
        end

        // Reset in RUN at stage 5 aborts without a clear pulse.
        accept_window(10'd11, 10'd12);
        load_to_run();
        for (int i = 0; i < 5; i++) stage(1'b1);
        chk("mid_stage5", {run_ann, result_stage}, {1'b1, 4'd5});
        rst_n = 1'b0;
        step();
        chk("mid_rst_outputs", {run_ann, busy, win_ready, result_valid, timeout_err, ann_clear,
            load_start, result_face, result_stage}, 0);
        chk("mid_rst_counts", {win_count, face_count}, 0);
        chk("mid_rst_xy", {load_x, load_y}, 0);
        rst_n = 1'b1;
        step();
        chk("mid_rst_ready", {win_ready, ann_clear}, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
